// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush/forward sequencer (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1, id_rs2;
    logic             id_use_rs1, id_use_rs2;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic             ex_memread, ex_pcsel;
    logic [4:0]       mem_rd, wb_rd;
    logic             mem_regwrite, wb_regwrite;
    logic             mem_req, mem_ready;
    logic             halt_req, resume;

    logic             pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic             if_id_flush, id_ex_flush, mem_wb_flush;
    logic [1:0]       fwd_a, fwd_b;
    logic [1:0]       state;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_memread, ex_pcsel, mem_rd, wb_rd, mem_regwrite, wb_regwrite,
               mem_req, mem_ready, halt_req, resume,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_flush,
               fwd_a, fwd_b, state, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_memread, ex_pcsel, mem_rd, wb_rd, mem_regwrite, wb_regwrite,
               mem_req, mem_ready, halt_req, resume,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_flush,
               fwd_a, fwd_b, state, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage RV32I pipeline: load-use,
// taken control flow, data-memory waits with timeout, and halt/drain.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        DRAIN   = 2'b10,
        HALT    = 2'b11
    } state_t;

    state_t             cur, nxt;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               stall_inc, flush_inc;
    logic               freeze, load_use, run_rules, hold;
    logic               pc_we, ifid_we, idex_we, exmem_we;
    logic               ifid_fl, idex_fl, memwb_fl;

    assign freeze   = hz.mem_req && !hz.mem_ready;
    assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                       (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));

    assign hz.fwd_a = (hz.mem_regwrite && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs1) ? 2'b10 :
                      (hz.wb_regwrite  && hz.wb_rd  != 5'd0 && hz.wb_rd  == hz.ex_rs1) ? 2'b01 : 2'b00;
    assign hz.fwd_b = (hz.mem_regwrite && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs2) ? 2'b10 :
                      (hz.wb_regwrite  && hz.wb_rd  != 5'd0 && hz.wb_rd  == hz.ex_rs2) ? 2'b01 : 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= RUN;
            wait_q  <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            cur     <= nxt;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (flush_inc && flush_q != '1) flush_q <= flush_q + 1'b1;
        end
    end

    always_comb begin
        nxt       = cur;
        wait_d    = wait_q;
        drain_d   = drain_q;
        err_d     = err_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        run_rules = 1'b0;
        hold      = 1'b0;
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        idex_we   = 1'b1;
        exmem_we  = 1'b1;
        ifid_fl   = 1'b0;
        idex_fl   = 1'b0;
        memwb_fl  = 1'b0;

        case (cur)
            RUN: begin
                if (freeze) begin
                    hold   = 1'b1;
                    nxt    = MEMWAIT;
                    wait_d = WAIT_W'(1);
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEMWAIT: begin
                stall_inc = 1'b1;
                if (freeze) begin
                    hold = 1'b1;
                    if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        err_d = 1'b1;
                        nxt   = HALT;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end else begin
                    run_rules = 1'b1;
                    nxt       = RUN;
                end
            end
            DRAIN: begin
                if (freeze) begin
                    hold = 1'b1;
                end else begin
                    pc_we   = 1'b0;
                    ifid_fl = 1'b1;
                    if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) nxt = HALT;
                    else                                        drain_d = drain_q + 1'b1;
                end
            end
            default: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                idex_we  = 1'b0;
                exmem_we = 1'b0;
                if (hz.resume && !err_q) nxt = RUN;
            end
        endcase

        if (hold) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_fl = 1'b1;
        end

        // The cycle memory completes is a full RUN cycle, including a halt_req
        // in ID, so the ecall is not lost while leaving MEMWAIT.
        if (run_rules) begin
            if (hz.ex_pcsel) begin
                ifid_fl   = 1'b1;
                idex_fl   = 1'b1;
                flush_inc = 1'b1;
            end else if (load_use) begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                idex_fl   = 1'b1;
                stall_inc = 1'b1;
            end else if (hz.halt_req) begin
                pc_we   = 1'b0;
                ifid_fl = 1'b1;
                nxt     = DRAIN;
                drain_d = '0;
            end
        end
    end

    assign hz.pc_write     = pc_we;
    assign hz.if_id_write  = ifid_we;
    assign hz.id_ex_write  = idex_we;
    assign hz.ex_mem_write = exmem_we;
    assign hz.if_id_flush  = ifid_fl;
    assign hz.id_ex_flush  = idex_fl;
    assign hz.mem_wb_flush = memwb_fl;
    assign hz.state        = cur;
    assign hz.mem_err      = err_q;
    assign hz.stall_cnt    = stall_q;
    assign hz.flush_cnt    = flush_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forward sequencer for the 5-stage RV32I pipeline.
- Drives the write-enables and flushes of the four pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Resolves load-use hazards, taken branches/jumps, multi-cycle data-memory waits, and a halt/drain sequence; selects EX-stage forwarding sources.
- Keeps saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEMWAIT cycles before error
DRAIN_CYCLES, 4, cycles spent draining before HALT
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
id_rs1, id_rs2  in  5 each  source regs of instr in ID
id_use_rs1, id_use_rs2  in  1 each  ID instr actually reads rs1/rs2
ex_rs1, ex_rs2  in  5 each  source regs of instr in EX
ex_rd  in  5  dest reg in EX
ex_memread  in  1  EX instr is a load
ex_pcsel  in  1  branch taken / jal / jalr resolved in EX
mem_rd, wb_rd  in  5 each  dest regs in MEM, WB
mem_regwrite, wb_regwrite  in  1 each  RegWrite of MEM, WB
mem_req  in  1  MEM stage holds a load/store
mem_ready  in  1  data memory completes this cycle
halt_req  in  1  ID decoded ecall/ebreak (level)
resume  in  1  leave HALT
pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  register enables
if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  insert bubble (sync clear)
fwd_a, fwd_b  out  2 each  00 regfile, 10 EX/MEM ALU result, 01 MEM/WB writeback
state  out  2  00 RUN, 01 MEMWAIT, 10 DRAIN, 11 HALT
mem_err  out  1  sticky timeout flag
stall_cnt, flush_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset (async, active-high):
  - state=RUN, mem_err=0, counters=0, internal wait/drain counters=0.
  - All enables=1, all flushes=0, fwd=00.
- Forwarding (combinational, every state):
  - fwd_a=10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs1.
  - Else fwd_a=01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1.
  - Else fwd_a=00. fwd_b identical using ex_rs2.
  - MEM has priority over WB. x0 is never forwarded.
- freeze = mem_req && !mem_ready. Priority while in RUN: freeze > ex_pcsel > load-use > halt_req.
- RUN, freeze:
  - All enables=0, mem_wb_flush=1, other flushes=0.
  - Next state=MEMWAIT; wait counter=1.
- RUN, ex_pcsel:
  - pc_write=1, if_id_flush=1, id_ex_flush=1.
  - flush_cnt+1.
  - Any load-use hazard or halt_req in ID is discarded.
- RUN, load-use:
  - Condition: ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt+1. Exactly 1 bubble.
- RUN, halt_req:
  - pc_write=0, if_id_flush=1 (ecall not propagated past ID).
  - Next state=DRAIN; drain counter=0.
- MEMWAIT:
  - Same outputs as the freeze case; ex_pcsel is ignored (held in EX, acted on after exit); stall_cnt+1 per cycle.
  - mem_ready=1: outputs revert to RUN rules that same cycle; next state=RUN.
  - Wait counter reaches MEM_TIMEOUT without mem_ready: mem_err=1; next state=HALT.
- DRAIN:
  - pc_write=0, if_id_flush=1; other stages advance normally.
  - freeze still applies and pauses the drain counter.
  - Drain counter increments per unfrozen cycle; at DRAIN_CYCLES-1, next state=HALT.
- HALT:
  - All enables=0, all flushes=0.
  - resume=1 && mem_err=0: next state=RUN.
  - mem_err cleared only by reset.
- Counters: saturate at all-ones, no wrap.
- Reset mid-MEMWAIT/DRAIN: immediate return to RUN values; no partial state retained.

Test Plan:
1. lw x5 in EX (ex_memread=1, ex_rd=5); ID add reads rs1=5 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt=1; next cycle all enables=1.
2. ex_pcsel=1 in the same cycle as the scenario-1 load-use condition -> if_id_flush=id_ex_flush=1, pc_write=1, stall_cnt unchanged, flush_cnt=1.
3. mem_req=1, mem_ready=0 for 3 cycles then 1 -> state MEMWAIT for 3 cycles, enables=0, mem_wb_flush=1; RUN on ready; stall_cnt=3.
4. mem_req=1, mem_ready held 0 with MEM_TIMEOUT=64 -> mem_err=1 and state=HALT after cycle 64; resume ignored; reset clears.
5. halt_req pulse -> 4 DRAIN cycles with if_id_flush=1, then HALT with all enables=0; resume=1 -> RUN next cycle.
6. ex_rs1=3 with mem_rd=3/mem_regwrite=1 and wb_rd=3/wb_regwrite=1 -> fwd_a=10; mem_rd=0 variant -> fwd_a=01; ex_rs1=0 -> fwd_a=00.
